issue_decouple_queue: RTL and testbench
=======================================

ISSUE_DECOUPLE_QUEUE -- requirements
Module: issue_decouple_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, the core configuration.
REQ-002 SHALL have parameter type entry_t, default ariane_pkg::scoreboard_entry_t, the payload type.
REQ-003 SHALL have parameter DEPTH, default 4, the entry count (power of two, >=2).
REQ-004 SHALL have parameter MAX_UNRESOLVED, default 2, the maximum number of unresolved control-flow entries (>=1).
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, the reset: asynchronous, active-high.
REQ-007 SHALL have port flush_i, input, 1, which discards all held entries.
REQ-008 SHALL have port stall_i, input, 1, which blocks dequeue.
REQ-009 SHALL have port valid_i, input, 1, decoded-instruction valid.
REQ-010 SHALL have port data_i, input, entry_t, the decoded instruction.
REQ-011 SHALL have port is_ctrl_flow_i, input, 1, which marks data_i as a branch or jump.
REQ-012 SHALL have port ready_o, output, 1, enqueue acknowledge.
REQ-013 SHALL have port valid_o, output, 1, head valid toward the scoreboard.
REQ-014 SHALL have port data_o, output, entry_t, the head entry.
REQ-015 SHALL have port ready_i, input, 1, scoreboard accept.
REQ-016 SHALL have port resolve_branch_i, input, 1, which marks one control-flow instruction as resolved.
REQ-017 SHALL have port usage_o, output, $clog2(DEPTH+1), the occupied entries.
REQ-018 SHALL have port unresolved_o, output, $clog2(MAX_UNRESOLVED+1), the unresolved control-flow count.
REQ-019 SHALL have port cf_stall_o, output, 1, which flags an enqueue blocked by the control-flow limit (for perf counters).

Function
REQ-020 An enqueue SHALL occur when valid_i & ready_o; a dequeue SHALL occur when valid_o & ready_i.
REQ-021 ready_o SHALL equal !full & !flush_i & !(is_ctrl_flow_i & unresolved_o==MAX_UNRESOLVED), with no combinational dependence on ready_i.
REQ-022 valid_o SHALL equal !empty & !stall_i & !flush_i.
REQ-023 Enqueue-to-valid_o latency SHALL be 1 cycle, with no same-cycle bypass when empty.
REQ-024 data_o SHALL be the storage entry at the read pointer regardless of valid_o.
REQ-025 Entries SHALL leave in strict FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Simultaneous enqueue and dequeue SHALL leave usage_o unchanged; at full, no enqueue SHALL occur even if a dequeue happens in the same cycle.
REQ-027 unresolved_o SHALL increment on enqueue of an entry with is_ctrl_flow_i=1 and decrement on resolve_branch_i.
REQ-028 When the increment and decrement of unresolved_o occur in the same cycle, unresolved_o SHALL be unchanged.
REQ-029 resolve_branch_i at count 0 SHALL leave unresolved_o at 0, with no underflow.
REQ-030 cf_stall_o SHALL equal valid_i & is_ctrl_flow_i & !full & !flush_i & unresolved_o==MAX_UNRESOLVED.
REQ-031 flush_i SHALL have priority over enqueue, dequeue and resolve: the next cycle, pointers=0, usage_o=0 and unresolved_o=0; storage contents are kept.
REQ-032 stall_i SHALL NOT block enqueue.

Reset
REQ-033 On rst_i, pointers, usage_o and unresolved_o SHALL clear immediately, and storage SHALL be set to '0.
REQ-034 During reset, outputs SHALL be valid_o=0, ready_o=1 (except when flush_i=1), data_o='0 and cf_stall_o=0.
REQ-035 Reset asserted mid-operation SHALL drop all entries without emitting a partial dequeue.

Structure
REQ-036 The DEPTH default SHALL be the constant ISSUE_QUEUE_DEPTH, and the MAX_UNRESOLVED default SHALL be ISSUE_MAX_UNRESOLVED, both in ariane_pkg.
REQ-037 entry_t SHALL be passed through from ariane_pkg, with no new typedef.
REQ-038 The saturating up/down counter SHALL be a single sub-module, issue_cf_counter.

Verification
REQ-039 Fill scenario: DEPTH=4, ready_i=0, enqueue 5 entries -> ready_o=0 after the 4th, usage_o=4, the 5th is held by the source.
REQ-040 Order/wrap scenario: 10 entries A..J with ready_i=1 -> output order A..J, pointers wrapped twice, 1-cycle latency each.
REQ-041 Control-flow limit scenario: MAX_UNRESOLVED=2, enqueue 3 branches -> third: ready_o=0 and cf_stall_o=1; resolve_branch_i pulse -> third accepted next cycle, unresolved_o=2.
REQ-042 Simultaneous scenario: usage_o=2, unresolved_o=1, branch enqueue + dequeue + resolve in one cycle -> usage_o=2, unresolved_o=1.
REQ-043 Flush scenario: usage_o=3, unresolved_o=2, flush_i with valid_i=1 -> nothing enqueued, next cycle usage_o=0, unresolved_o=0, valid_o=0.
REQ-044 Stall/reset scenario: stall_i=1 with usage_o=2 -> valid_o=0, enqueue still accepted (usage_o=3); rst_i pulse -> usage_o=0 immediately and data_o=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Core-wide constants and the scoreboard entry payload type.
package ariane_pkg;

  // Issue-queue sizing shared by every instance in the core.
  localparam int unsigned ISSUE_QUEUE_DEPTH    = 4;
  localparam int unsigned ISSUE_MAX_UNRESOLVED = 2;

  // Decoded instruction as it travels from decode into the scoreboard.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } scoreboard_entry_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration package.
// Holds the configuration record handed to core blocks and the empty
// configuration used as their default.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/issue_decouple_queue_pkg.sv
// Local types and helpers for the issue decouple queue and its
// control-flow counter.
package issue_decouple_queue_pkg;

  // Action taken by the unresolved control-flow counter in one cycle.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLEAR
  } cnt_op_e;

  // Combined queue action in one cycle.
  typedef enum logic [1:0] {
    Q_IDLE,
    Q_PUSH,
    Q_POP,
    Q_PUSH_POP
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    q_op_e op;
    case ({push, pop})
      2'b10:   op = Q_PUSH;
      2'b01:   op = Q_POP;
      2'b11:   op = Q_PUSH_POP;
      default: op = Q_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/issue_cf_counter.sv
// Saturating up/down counter tracking unresolved control-flow entries.
//
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset, clears the count
//   clear_i  - synchronous clear (flush), wins over inc/dec
//   inc_i    - a control-flow entry was accepted
//   dec_i    - a control-flow entry was resolved
//   count_o  - current count
//   at_max_o - count has reached MAX_COUNT
module issue_cf_counter
  import issue_decouple_queue_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 2,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             dec_eff;
  cnt_op_e          op;

  // A resolve with nothing outstanding is ignored so the count never
  // wraps below zero.
  assign dec_eff = dec_i && (count_reg != '0);

  always_comb begin
    op = CNT_HOLD;
    if (clear_i) begin
      op = CNT_CLEAR;
    end else if (inc_i && !dec_eff) begin
      op = CNT_INC;
    end else if (dec_eff && !inc_i) begin
      op = CNT_DEC;
    end
  end

  always_comb begin
    count_next = count_reg;
    case (op)
      CNT_CLEAR: count_next = '0;
      CNT_INC:   if (count_reg != MAX_VAL) count_next = count_reg + 1'b1;
      CNT_DEC:   count_next = count_reg - 1'b1;
      default:   count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_o  = count_reg;
  assign at_max_o = (count_reg == MAX_VAL);

endmodule

// File: rtl/issue_decouple_queue.sv
// Decouples decode from the scoreboard with a small FIFO and limits how
// many unresolved branches/jumps may be in flight behind it.
//
// Ports:
//   clk_i            - clock
//   rst_i            - asynchronous active-high reset
//   flush_i          - drop every held entry and the unresolved count
//   stall_i          - hold the head back from the scoreboard
//   valid_i/data_i   - decoded instruction offered for enqueue
//   is_ctrl_flow_i   - data_i is a branch or jump
//   ready_o          - enqueue accepted this cycle when valid_i is high
//   valid_o/data_o   - head entry toward the scoreboard
//   ready_i          - scoreboard takes the head
//   resolve_branch_i - one control-flow instruction has resolved
//   usage_o          - number of occupied entries
//   unresolved_o     - number of unresolved control-flow entries
//   cf_stall_o       - enqueue blocked only by the control-flow limit
module issue_decouple_queue
  import issue_decouple_queue_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type entry_t                   = ariane_pkg::scoreboard_entry_t,
  parameter int unsigned DEPTH             = ariane_pkg::ISSUE_QUEUE_DEPTH,
  parameter int unsigned MAX_UNRESOLVED    = ariane_pkg::ISSUE_MAX_UNRESOLVED
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                valid_i,
  input  entry_t                              data_i,
  input  logic                                is_ctrl_flow_i,
  output logic                                ready_o,
  output logic                                valid_o,
  output entry_t                              data_o,
  input  logic                                ready_i,
  input  logic                                resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0]          usage_o,
  output logic [$clog2(MAX_UNRESOLVED+1)-1:0] unresolved_o,
  output logic                                cf_stall_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned USAGE_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W   = $clog2(MAX_UNRESOLVED + 1);

  // The configuration record carries nothing this block needs today.
  logic cfg_unused;
  assign cfg_unused = ^CVA6Cfg.XLEN;

  entry_t             mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [USAGE_W-1:0] usage_reg, usage_next;
  logic [DEPTH-1:0]   wr_en;

  logic full, empty, cf_at_max, enq, deq;

  assign full  = (usage_reg == USAGE_W'(DEPTH));
  assign empty = (usage_reg == '0);

  // ready_o deliberately ignores ready_i: a full queue refuses new work
  // even if the head leaves in the same cycle.
  assign ready_o    = !full && !flush_i && !(is_ctrl_flow_i && cf_at_max);
  assign valid_o    = !empty && !stall_i && !flush_i;
  assign cf_stall_o = valid_i && is_ctrl_flow_i && !full && !flush_i && cf_at_max;

  assign enq = valid_i && ready_o;
  assign deq = valid_o && ready_i;

  // Head is exposed straight from storage; valid_o qualifies it.
  assign data_o = mem_reg[rd_ptr_reg];

  // One-hot write select for the slot under the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = enq && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= data_i;
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Flush
  // rewinds them but leaves storage untouched.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    usage_next  = usage_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      usage_next  = '0;
    end else begin
      if (enq) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_next = rd_ptr_reg + 1'b1;
      case (q_op(enq, deq))
        Q_PUSH:  usage_next = usage_reg + 1'b1;
        Q_POP:   usage_next = usage_reg - 1'b1;
        default: usage_next = usage_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      usage_reg  <= usage_next;
    end
  end

  assign usage_o = usage_reg;

  issue_cf_counter #(
    .MAX_COUNT (MAX_UNRESOLVED),
    .CNT_W     (CNT_W)
  ) u_cf_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_i),
    .inc_i    (enq && is_ctrl_flow_i),
    .dec_i    (resolve_branch_i),
    .count_o  (unresolved_o),
    .at_max_o (cf_at_max)
  );

endmodule

// File: tb/tb_issue_decouple_queue.sv
module tb_issue_decouple_queue;
  import ariane_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, flush_i, stall_i, valid_i, is_ctrl_flow_i;
  logic              ready_i, resolve_branch_i;
  scoreboard_entry_t data_i, data_o;
  logic              ready_o, valid_o, cf_stall_o;
  logic [2:0]        usage_o;
  logic [1:0]        unresolved_o;

  int checks   = 0;
  int failures = 0;

  issue_decouple_queue #(
    .CVA6Cfg        (config_pkg::cva6_cfg_empty),
    .entry_t        (scoreboard_entry_t),
    .DEPTH          (4),
    .MAX_UNRESOLVED (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .stall_i          (stall_i),
    .valid_i          (valid_i),
    .data_i           (data_i),
    .is_ctrl_flow_i   (is_ctrl_flow_i),
    .ready_o          (ready_o),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .ready_i          (ready_i),
    .resolve_branch_i (resolve_branch_i),
    .usage_o          (usage_o),
    .unresolved_o     (unresolved_o),
    .cf_stall_o       (cf_stall_o)
  );

  function automatic scoreboard_entry_t mk(input int n);
    scoreboard_entry_t e;
    e.pc    = 32'h8000_0000 + 32'(n) * 32'd4;
    e.fu    = 4'(n);
    e.op    = 8'(n * 3);
    e.rs1   = 5'(n);
    e.rs2   = 5'(n + 1);
    e.rd    = 5'(n + 2);
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
    is_ctrl_flow_i = 1'b0; ready_i = 1'b0; resolve_branch_i = 1'b0;
    data_i = '0;
    #2;
    // Outputs while reset is held
    chk("rst_valid",      64'(valid_o),      64'(0));
    chk("rst_ready",      64'(ready_o),      64'(1));
    chk("rst_data",       64'(data_o),       64'(0));
    chk("rst_cf_stall",   64'(cf_stall_o),   64'(0));
    chk("rst_usage",      64'(usage_o),      64'(0));
    chk("rst_unresolved", 64'(unresolved_o), 64'(0));
    flush_i = 1'b1; #1;
    chk("rst_ready_flush", 64'(ready_o), 64'(0));
    flush_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Fill: five offered, four accepted, no dequeue
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = mk(i); #1;
      chk("fill_ready", 64'(ready_o), 64'(i < 4));
      if (i == 0) chk("fill_no_bypass", 64'(valid_o), 64'(0));
      tick();
      chk("fill_usage", 64'(usage_o), 64'((i < 4) ? i + 1 : 4));
      chk("fill_valid", 64'(valid_o), 64'(1));
    end
    valid_i = 1'b0;
    chk("fill_head", 64'(data_o), 64'(mk(0)));

    // Drain in order
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", 64'(valid_o), 64'(1));
      chk("drain_data",  64'(data_o),  64'(mk(k)));
      tick();
    end
    chk("drain_usage", 64'(usage_o), 64'(0));
    chk("drain_valid_end", 64'(valid_o), 64'(0));

    // Streaming ten entries through, one cycle latency each
    for (int k = 0; k <= 10; k++) begin
      valid_i = (k < 10); data_i = mk(10 + k); #1;
      chk("stream_valid", 64'(valid_o), 64'(k > 0));
      if (k > 0) chk("stream_data", 64'(data_o), 64'(mk(9 + k)));
      chk("stream_ready", 64'(ready_o), 64'(1));
      tick();
    end
    valid_i = 1'b0;
    chk("stream_usage", 64'(usage_o), 64'(0));

    // Control-flow limit
    ready_i = 1'b0; valid_i = 1'b1; is_ctrl_flow_i = 1'b1;
    data_i = mk(30); #1;
    chk("cf1_ready", 64'(ready_o), 64'(1));
    chk("cf1_stall", 64'(cf_stall_o), 64'(0));
    tick();
    chk("cf1_unres", 64'(unresolved_o), 64'(1));
    data_i = mk(31); #1;
    chk("cf2_ready", 64'(ready_o), 64'(1));
    tick();
    chk("cf2_unres", 64'(unresolved_o), 64'(2));
    data_i = mk(32); #1;
    chk("cf3_ready", 64'(ready_o), 64'(0));
    chk("cf3_stall", 64'(cf_stall_o), 64'(1));
    tick();
    chk("cf3_usage", 64'(usage_o), 64'(2));
    chk("cf3_unres", 64'(unresolved_o), 64'(2));
    resolve_branch_i = 1'b1; #1;
    chk("cf_resolve_ready", 64'(ready_o), 64'(0));
    tick();
    resolve_branch_i = 1'b0;
    chk("cf_resolve_unres", 64'(unresolved_o), 64'(1));
    #1;
    chk("cf3_retry_ready", 64'(ready_o), 64'(1));
    chk("cf3_retry_stall", 64'(cf_stall_o), 64'(0));
    tick();
    chk("cf3_accept_usage", 64'(usage_o), 64'(3));
    chk("cf3_accept_unres", 64'(unresolved_o), 64'(2));
    is_ctrl_flow_i = 1'b0; data_i = mk(33); #1;
    chk("cf_nonbranch_ready", 64'(ready_o), 64'(1));
    chk("cf_nonbranch_stall", 64'(cf_stall_o), 64'(0));
    valid_i = 1'b0;
    chk("cf_head", 64'(data_o), 64'(mk(30)));
    chk("cf_head_valid", 64'(valid_o), 64'(1));

    // Bring to usage 2 / unresolved 1
    ready_i = 1'b1; resolve_branch_i = 1'b1; #1;
    tick();
    ready_i = 1'b0; resolve_branch_i = 1'b0;
    chk("sim_pre_usage", 64'(usage_o), 64'(2));
    chk("sim_pre_unres", 64'(unresolved_o), 64'(1));
    chk("sim_pre_head",  64'(data_o), 64'(mk(31)));

    // Branch enqueue + dequeue + resolve in one cycle
    valid_i = 1'b1; is_ctrl_flow_i = 1'b1; data_i = mk(40);
    ready_i = 1'b1; resolve_branch_i = 1'b1; #1;
    chk("sim_ready", 64'(ready_o), 64'(1));
    chk("sim_valid", 64'(valid_o), 64'(1));
    tick();
    valid_i = 1'b0; is_ctrl_flow_i = 1'b0; ready_i = 1'b0; resolve_branch_i = 1'b0;
    chk("sim_usage", 64'(usage_o), 64'(2));
    chk("sim_unres", 64'(unresolved_o), 64'(1));
    chk("sim_head",  64'(data_o), 64'(mk(32)));

    // Bring to usage 3 / unresolved 2, then flush
    valid_i = 1'b1; is_ctrl_flow_i = 1'b1; data_i = mk(41); #1;
    tick();
    valid_i = 1'b0; is_ctrl_flow_i = 1'b0;
    chk("fl_pre_usage", 64'(usage_o), 64'(3));
    chk("fl_pre_unres", 64'(unresolved_o), 64'(2));
    flush_i = 1'b1; valid_i = 1'b1; data_i = mk(42);
    ready_i = 1'b1; resolve_branch_i = 1'b1; #1;
    chk("fl_ready", 64'(ready_o), 64'(0));
    chk("fl_valid", 64'(valid_o), 64'(0));
    chk("fl_cf_stall", 64'(cf_stall_o), 64'(0));
    tick();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; resolve_branch_i = 1'b0; #1;
    chk("fl_usage", 64'(usage_o), 64'(0));
    chk("fl_unres", 64'(unresolved_o), 64'(0));
    chk("fl_valid_after", 64'(valid_o), 64'(0));
    chk("fl_storage_kept", 64'(data_o), 64'(mk(32)));

    // Stall blocks dequeue but not enqueue
    stall_i = 1'b1; ready_i = 1'b1; valid_i = 1'b1; data_i = mk(50); #1;
    tick();
    data_i = mk(51);
    tick();
    valid_i = 1'b0;
    chk("st_usage2", 64'(usage_o), 64'(2));
    #1;
    chk("st_valid", 64'(valid_o), 64'(0));
    chk("st_head", 64'(data_o), 64'(mk(50)));
    valid_i = 1'b1; data_i = mk(52); #1;
    chk("st_ready", 64'(ready_o), 64'(1));
    tick();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("st_usage3", 64'(usage_o), 64'(3));
    stall_i = 1'b0; #1;
    chk("st_release_valid", 64'(valid_o), 64'(1));

    // Reset mid-operation
    rst_i = 1'b1; #1;
    chk("mr_usage", 64'(usage_o), 64'(0));
    chk("mr_valid", 64'(valid_o), 64'(0));
    chk("mr_data",  64'(data_o),  64'(0));
    chk("mr_unres", 64'(unresolved_o), 64'(0));
    chk("mr_ready", 64'(ready_o), 64'(1));
    tick();
    chk("mr_usage_held", 64'(usage_o), 64'(0));
    rst_i = 1'b0; #1;

    // Resolve with nothing outstanding
    resolve_branch_i = 1'b1;
    tick();
    resolve_branch_i = 1'b0;
    chk("uf_unres", 64'(unresolved_o), 64'(0));

    // Normal operation after reset
    valid_i = 1'b1; data_i = mk(60); #1;
    chk("post_no_bypass", 64'(valid_o), 64'(0));
    tick();
    valid_i = 1'b0;
    chk("post_usage", 64'(usage_o), 64'(1));
    chk("post_valid", 64'(valid_o), 64'(1));
    chk("post_data",  64'(data_o),  64'(mk(60)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
